// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux_rr round-robin stream multiplexer.
// Optional per-channel burst counters are enabled with STREAM_MUX_RR_GRANT_CNT_EN.
package stream_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Rotate-priority pick for up to 16 requesters: returns {found, idx}.
  // The search starts at ptr and wraps at n-1 back to 0; ptr must be < n.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input int unsigned n);
    logic [4:0]  res;
    int unsigned idx;
    res = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !res[4] && valid[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Combinational rotate-priority arbiter used by stream_mux_rr in round-robin mode.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] i_valid,
  input  logic [SW-1:0]   i_ptr,
  output logic            o_found,
  output logic [SW-1:0]   o_idx
);

  logic [4:0] w_pick;

  // Pick the first valid channel at or above the pointer, wrapping around.
  always_comb begin
    w_pick  = rr_pick(16'(i_valid), 4'(i_ptr), N_CH);
    o_found = w_pick[4];
    o_idx   = SW'(w_pick[3:0]);
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with registered output, fixed-select or
// round-robin arbitration, and burst locking on per-channel last flags.
// Define STREAM_MUX_RR_GRANT_CNT_EN to add per-channel completed-burst counters.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DW   = 8,
  parameter int SW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [SW-1:0]     s,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH-1:0]   in_last,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic [DW-1:0]     out_data,
  output logic [SW-1:0]     out_ch,
  input  logic              out_ready,
  output logic              busy
`ifdef STREAM_MUX_RR_GRANT_CNT_EN
  ,
  output logic [N_CH*16-1:0] grant_cnt
`endif
);

  state_t          r_state;
  logic [SW-1:0]   r_lock_ch;
  logic [SW-1:0]   r_ptr;
  logic            r_out_valid;
  logic            r_out_last;
  logic [DW-1:0]   r_out_data;
  logic [SW-1:0]   r_out_ch;

  logic            w_arb_found;
  logic [SW-1:0]   w_arb_idx;
  logic [SW-1:0]   w_g;
  logic            w_gv;
  logic            w_g_last;
  logic [DW-1:0]   w_g_data;
  logic            w_load;
  logic            w_accept;
  logic [SW-1:0]   w_ptr_next;

  rr_arbiter #(.N_CH(N_CH), .SW(SW)) u_arb (
    .i_valid (in_valid),
    .i_ptr   (r_ptr),
    .o_found (w_arb_found),
    .o_idx   (w_arb_idx)
  );

  // Select the granted channel and fetch its valid/last/data.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_gv     = 1'b0;
    w_g_last = 1'b0;
    w_g_data = '0;
    if (r_state == ST_LOCK)      w_g = r_lock_ch;
    else if (mode == MODE_SEL)   w_g = s;
    else                         w_g = w_arb_idx;
    // The arbiter only reports a valid channel, and an out-of-range s matches
    // no channel here, so in_valid[g] is the grant-valid in every mode.
    for (int i = 0; i < N_CH; i++) begin
      if (w_g == SW'(i)) begin
        w_gv     = in_valid[i];
        w_g_last = in_last[i];
        w_g_data = in_data[i*DW +: DW];
      end
    end
    w_load     = ~r_out_valid | out_ready;
    w_accept   = w_load & w_gv & ~rst;
    w_ptr_next = (w_g == SW'(N_CH - 1)) ? '0 : w_g + SW'(1);
    for (int i = 0; i < N_CH; i++) in_ready[i] = w_accept & (w_g == SW'(i));
  end

  // FSM, round-robin pointer and output register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lock_ch   <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else begin
      if (w_load) r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_last <= w_g_last;
        r_out_data <= w_g_data;
        r_out_ch   <= w_g;
        if (w_g_last) r_ptr <= w_ptr_next;
        case (r_state)
          ST_IDLE: if (!w_g_last) begin
            r_state   <= ST_LOCK;
            r_lock_ch <= w_g;
          end
          ST_LOCK: if (w_g_last) r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign busy      = (r_state == ST_LOCK);

`ifdef STREAM_MUX_RR_GRANT_CNT_EN
  logic [15:0] r_grant_cnt [N_CH];

  // Count completed bursts per channel, saturating at all-ones.
  always_ff @(posedge clk) begin
    // NOTE: the counter array is small register state, so it is cleared explicitly on reset.
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_accept && w_g_last && (w_g == SW'(i)) && (r_grant_cnt[i] != 16'hFFFF))
          r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
      end
    end
  end

  // Flatten the counters onto the packed output port.
  always_comb begin
    for (int i = 0; i < N_CH; i++) grant_cnt[i*16 +: 16] = r_grant_cnt[i];
  end
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (N_CH=8, DW=8) with a beat scoreboard.
module tb_stream_mux_rr;

  localparam int N_CH = 8;
  localparam int DW   = 8;
  localparam int SW   = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [SW-1:0]     s;
  logic [N_CH-1:0]   in_valid;
  logic [N_CH-1:0]   in_last;
  logic [N_CH*DW-1:0] in_data;
  logic [N_CH-1:0]   in_ready;
  logic              out_valid;
  logic              out_last;
  logic [DW-1:0]     out_data;
  logic [SW-1:0]     out_ch;
  logic              out_ready;
  logic              busy;
`ifdef STREAM_MUX_RR_GRANT_CNT_EN
  logic [N_CH*16-1:0] grant_cnt;
`endif

  stream_mux_rr #(.N_CH(N_CH), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .s         (s),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .busy      (busy)
`ifdef STREAM_MUX_RR_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t sb[$];
  beat_t cur;
  logic  cur_valid = 1'b0;
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check in_ready before the edge, predict the accepted beat,
  // then check the output register and busy one cycle later.
  task automatic step(input logic acc, input int ch, input logic exp_busy);
    beat_t b;
    logic  rdy_at_edge;
    logic  rst_at_edge;
    #1;
    check("in_ready", 64'(in_ready), acc ? 64'(8'(1) << ch) : 64'h0);
    if (acc) begin
      b.ch   = SW'(ch);
      b.data = in_data[ch*DW +: DW];
      b.last = in_last[ch];
      sb.push_back(b);
    end
    rdy_at_edge = out_ready;
    rst_at_edge = rst;
    @(posedge clk);
    #1;
    if (rst_at_edge) begin
      sb.delete();
      cur_valid = 1'b0;
    end else if (acc) begin
      cur       = sb.pop_front();
      cur_valid = 1'b1;
    end else if (rdy_at_edge) begin
      cur_valid = 1'b0;
    end
    check("out_valid", 64'(out_valid), 64'(cur_valid));
    if (cur_valid) begin
      check("out_data", 64'(out_data), 64'(cur.data));
      check("out_ch",   64'(out_ch),   64'(cur.ch));
      check("out_last", 64'(out_last), 64'(cur.last));
    end
    check("busy", 64'(busy), 64'(exp_busy));
  endtask

  task automatic set_bytes(input logic [7:0] base);
    for (int i = 0; i < N_CH; i++) in_data[i*DW +: DW] = base + 8'(i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; s = '0; in_valid = '1; in_last = '1;
    in_data = '0; out_ready = 1'b1;

    // Reset state
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_out_ch",   64'(out_ch),   64'h0);
    check("rst_out_last", 64'(out_last), 64'h0);
    rst = 1'b0;

    // Fixed-select sweep
    mode = 1'b0; in_last = '1; set_bytes(8'hA0);
    for (int k = 0; k < N_CH; k++) begin
      s = SW'(k); in_valid = 8'(1) << k;
      step(1'b1, k, 1'b0);
    end
    in_valid = '0;
    step(1'b0, 0, 1'b0);

    // Round-robin fairness: pointer is 0 after the ch7 last beat
    mode = 1'b1; in_valid = '1; in_last = '1;
    for (int k = 0; k < 16; k++) step(1'b1, k % N_CH, 1'b0);

    // Burst lock on ch2 while ch5 stays valid; pointer is 0 again
    in_valid = 8'h24; in_last = 8'h20;
    in_data[2*DW +: DW] = 8'h21; in_data[5*DW +: DW] = 8'h55;
    step(1'b1, 2, 1'b1);
    mode = 1'b0; s = 3'd5; in_data[2*DW +: DW] = 8'h22;
    step(1'b1, 2, 1'b1);
    mode = 1'b1; in_valid = 8'h20;
    step(1'b0, 0, 1'b1);
    in_valid = 8'h24; in_last = 8'h24; in_data[2*DW +: DW] = 8'h23;
    step(1'b1, 2, 1'b0);
    in_valid = 8'h20;
    step(1'b1, 5, 1'b0);

    // Backpressure: pointer is 6
    in_valid = '1; in_last = '1; set_bytes(8'hC0);
    step(1'b1, 6, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b0);
    out_ready = 1'b1;
    step(1'b1, 7, 1'b0);
    step(1'b1, 0, 1'b0);

    // Reset in the middle of a ch3 burst
    mode = 1'b0; s = 3'd3; in_valid = 8'h08; in_last = 8'h00;
    step(1'b1, 3, 1'b1);
    step(1'b1, 3, 1'b1);
    rst = 1'b1;
    step(1'b0, 0, 1'b0);
    check("midrst_out_data", 64'(out_data), 64'h0);
    check("midrst_out_ch",   64'(out_ch),   64'h0);
    rst = 1'b0; mode = 1'b1; in_valid = '1; in_last = '1;
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);

`ifdef STREAM_MUX_RR_GRANT_CNT_EN
    // Five single-beat bursts on ch1 after a fresh reset
    rst = 1'b1;
    step(1'b0, 0, 1'b0);
    rst = 1'b0; mode = 1'b0; s = 3'd1; in_valid = 8'h02; in_last = '1;
    for (int k = 0; k < 5; k++) step(1'b1, 1, 1'b0);
    in_valid = '0;
    step(1'b0, 0, 1'b0);
    for (int i = 0; i < N_CH; i++)
      check($sformatf("grant_cnt[%0d]", i), 64'(grant_cnt[i*16 +: 16]), (i == 1) ? 64'd5 : 64'd0);
`endif

    check("sb_empty", 64'(sb.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the team's 8:1 combinational mux: an N-channel valid/ready stream multiplexer with a registered output stage.
- Two selection modes: external select (the classic mux behaviour, now with a handshake) and round-robin arbitration.
- Burst locking via per-channel last flags keeps multi-beat transfers contiguous.
- Sits between N producer channels and a single downstream consumer.

Parameters:
- N_CH, 8, number of input channels (2..16).
- DW, 8, data width per channel.
- SW, $clog2(N_CH), select/channel-index width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- mode  in  1  0 = fixed select via s; 1 = round-robin.
- s  in  SW  channel select, used when mode=0.
- in_valid  in  N_CH  per-channel valid.
- in_last  in  N_CH  per-channel end-of-burst flag.
- in_data  in  N_CH*DW  packed data; channel i occupies [i*DW +: DW].
- in_ready  out  N_CH  per-channel ready, one-hot or zero.
- out_valid  out  1  output beat valid.
- out_last  out  1  last flag of the output beat.
- out_data  out  DW  output data.
- out_ch  out  SW  source channel of the output beat.
- out_ready  in  1  downstream ready.
- busy  out  1  high in the LOCK state.

Behaviour:
- Reset (rst=1 at a clk edge) takes priority over all other activity, including mid-burst:
  - out_valid=0, out_last=0, out_data=0, out_ch=0, busy=0.
  - FSM returns to IDLE; rr pointer=0, so channel 0 has highest priority.
  - in_ready=0 for all channels while rst=1.
- Output register:
  - load = ~out_valid | out_ready.
  - A beat accepted at edge k (in_valid[g] & in_ready[g]) appears on out_* after edge k, i.e. 1-cycle latency.
  - Throughput is 1 beat/cycle when out_ready is held high.
  - If out_valid & ~out_ready: out_* hold stable and in_ready is all-zero.
- Grant g is computed combinationally each cycle. in_ready[i] = load & (i==g) & grant_valid.
- FSM:
  - IDLE: choose g by mode.
    - mode=0: g=s; grant_valid=in_valid[s].
    - mode=1: g is the first channel with in_valid set, searching from ptr upward and wrapping at N_CH-1 to 0.
    - On accept with in_last[g]=0: go to LOCK, latch lock_ch=g.
    - On accept with in_last[g]=1: stay in IDLE (single-beat burst).
  - LOCK: g=lock_ch regardless of mode, s, or other valids; busy=1.
    - On accept with in_last=1: go to IDLE.
- Round-robin pointer:
  - Updates only on acceptance of a last beat: ptr = (g+1) mod N_CH.
  - Non-last beats and stalls leave ptr unchanged.
  - In mode=0 ptr is also updated on last-beat accept, so switching modes stays fair.
- Boundaries:
  - No valid requester: no accept; out_valid clears after the current beat drains.
  - In mode=0, a change of s or mode during LOCK is ignored until the burst ends.
  - An in_valid drop mid-burst in LOCK holds the lock; no other channel is served.
  - Accept and drain in the same cycle is legal: out_ready=1 with a new accept replaces the register contents.
  - An out-of-range s (N_CH not a power of 2) yields grant_valid=0.

Optional Feature:
- Macro: STREAM_MUX_RR_GRANT_CNT_EN.
- With the macro defined:
  - Adds output grant_cnt [N_CH*16]: per-channel 16-bit counters of accepted last beats (completed bursts).
  - Counters saturate at 16'hFFFF and reset to 0 on rst.
- Without the macro: no port and no counters; all other behaviour is identical.

Decomposition:
- Package stream_mux_pkg holds:
  - the state typedef (ST_IDLE, ST_LOCK);
  - the mode constants MODE_SEL=1'b0 and MODE_RR=1'b1;
  - the function rr_pick(valid, ptr) returning {found, idx}.
- Sub-module rr_arbiter (N_CH parameter): purely combinational rotate-priority pick from valid and ptr.
- FSM, pointer, output register, and optional counters live in the top module.

Test Plan:
- Fixed-select sweep (mode=0): for s=0..7 in turn, set in_valid=8'h01<<s, in_data[s]=s+8'hA0, in_last=all ones, out_ready=1. Required: out_data=A0+s and out_ch=s exactly one cycle after each accept; in_ready is one-hot at bit s.
- Round-robin fairness (mode=1): in_valid=8'hFF, all in_last=1, out_ready=1 for 16 cycles. Required: out_ch sequence 0,1,…,7,0,…,7 with no repeats.
- Burst lock (mode=1): ch2 sends 3 beats (last on beat 3) while ch5 is valid throughout. Required: out_ch=2 for 3 consecutive beats with busy=1, then out_ch=5.
- Backpressure: out_ready=0 for 4 cycles while out_valid=1. Required: out_data/out_ch stable and in_ready=0; after out_ready rises, resume with no loss or duplication.
- Reset mid-burst: assert rst during LOCK on ch3. Required:
  - next cycle out_valid=0, busy=0;
  - after release with in_valid=8'hFF, the first grant is ch0.
- With STREAM_MUX_RR_GRANT_CNT_EN: run 5 single-beat bursts on ch1. Required: grant_cnt for ch1 = 5, all others = 0.
